pc_ras_unit: RTL and testbench

//  Parametrised next-generation program counter with call/return support via an internal return-address stack (RAS).

---
 rtl/pc_ras_unit.sv | 170 +++++++++++++++++
 tb/tb_pc_ras_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: next-PC selection with a circular return-address stack (RAS) for call/return.
// Ports: clka/reset (sync, active-high); pc_latch_data advances state; pc_ctl selects the source;
//   imm/sr1_val supply relative/absolute targets; pc_out, ras_count/full/empty, err and trap are registered.
// Build option: define PC_TRAP_EN to redirect RAS faults and misaligned targets to TRAP_VEC with a trap pulse.
module pc_ras_unit #(
  parameter int PC_BITS   = 6,
  parameter int PC_STEP   = 2,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0,
  parameter int TRAP_VEC  = 0
) (
  input  logic                             clka,
  input  logic                             reset,
  input  logic                             pc_latch_data,
  input  logic [2:0]                       pc_ctl,
  input  logic [PC_BITS-1:0]               imm,
  input  logic [PC_BITS-1:0]               sr1_val,
  output logic [PC_BITS-1:0]               pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             err,
  output logic                             trap
);

  localparam int CNT_W = $clog2(RAS_DEPTH+1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [PC_BITS-1:0] LP_STEP     = PC_BITS'(PC_STEP);
  localparam logic [PC_BITS-1:0] LP_RESET_PC = PC_BITS'(RESET_PC);
  localparam logic [PC_BITS-1:0] LP_TRAP_VEC = PC_BITS'(TRAP_VEC);
  localparam logic [CNT_W-1:0]   LP_DEPTH    = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]   LP_PTR_LAST = PTR_W'(RAS_DEPTH-1);

  typedef enum logic [2:0] {
    CTL_SEQ   = 3'b000,
    CTL_REL   = 3'b001,
    CTL_ABS   = 3'b010,
    CTL_CALLR = 3'b011,
    CTL_CALLA = 3'b100,
    CTL_RET   = 3'b101
  } pc_ctl_e;

  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] r_ras [RAS_DEPTH];
  // r_wr_ptr is the next slot to write; when the stack is full it also points at the oldest entry,
  // so an overflowing push naturally overwrites it.
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_err;
  logic               r_trap;

  logic [PC_BITS-1:0] w_seq_pc;
  logic [PC_BITS-1:0] w_rel_pc;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic [PTR_W-1:0]   w_ptr_dec;
  logic               w_is_push;
  logic               w_is_pop;
  logic               w_taken;
  logic [PC_BITS-1:0] w_target;
  logic               w_overflow;
  logic               w_underflow;
  logic               w_fault;
  logic               w_do_push;
  logic               w_do_pop;
  logic [PC_BITS-1:0] w_pc_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;

  assign w_seq_pc  = r_pc + LP_STEP;
  assign w_rel_pc  = r_pc + imm;
  assign w_ptr_inc = (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_ptr_dec = (r_wr_ptr == '0) ? LP_PTR_LAST : r_wr_ptr - PTR_W'(1);

  // Decode the requested source; 11x falls through to sequential.
  always_comb begin
    w_is_push = 1'b0;
    w_is_pop  = 1'b0;
    w_taken   = 1'b0;
    w_target  = w_seq_pc;
    case (pc_ctl)
      CTL_REL:   begin w_taken = 1'b1; w_target = w_rel_pc; end
      CTL_ABS:   begin w_taken = 1'b1; w_target = sr1_val;  end
      CTL_CALLR: begin w_taken = 1'b1; w_target = w_rel_pc; w_is_push = 1'b1; end
      CTL_CALLA: begin w_taken = 1'b1; w_target = sr1_val;  w_is_push = 1'b1; end
      CTL_RET:   begin w_taken = 1'b1; w_target = r_ras[w_ptr_dec]; w_is_pop = 1'b1; end
      default:   ;
    endcase
  end

  assign w_overflow  = w_is_push && (r_count == LP_DEPTH);
  assign w_underflow = w_is_pop  && (r_count == '0);

`ifdef PC_TRAP_EN
  localparam logic [PC_BITS-1:0] LP_ALIGN_MASK = PC_BITS'(PC_STEP-1);
  logic w_misalign;
  assign w_misalign = w_taken && !w_underflow && ((w_target & LP_ALIGN_MASK) != '0);
  assign w_fault    = w_overflow || w_underflow || w_misalign;
`else
  logic w_unused_taken;
  assign w_unused_taken = w_taken;
  assign w_fault        = 1'b0;
`endif

  // Next-state selection. A fault redirects to the trap vector and leaves the RAS untouched.
  always_comb begin
    w_do_push   = 1'b0;
    w_do_pop    = 1'b0;
    w_pc_nxt    = w_target;
    w_count_nxt = r_count;
    w_ptr_nxt   = r_wr_ptr;
    if (w_fault) begin
      w_pc_nxt = LP_TRAP_VEC;
    end else if (w_underflow) begin
      w_pc_nxt = w_seq_pc;
    end else if (w_is_push) begin
      w_do_push = 1'b1;
      w_ptr_nxt = w_ptr_inc;
      if (!w_overflow) begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end else if (w_is_pop) begin
      w_do_pop    = 1'b1;
      w_ptr_nxt   = w_ptr_dec;
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      r_pc     <= LP_RESET_PC;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_err    <= 1'b0;
      r_trap   <= 1'b0;
    end else if (pc_latch_data) begin
      r_pc     <= w_pc_nxt;
      r_wr_ptr <= w_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == LP_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_err    <= r_err || w_overflow || w_underflow;
      r_trap   <= w_fault;
    end else begin
      r_trap   <= 1'b0;
    end
  end

  // Stack storage carries no reset; its contents are meaningless until pushed.
  always_ff @(posedge clka) begin
    if (!reset && pc_latch_data && w_do_push) begin
      r_ras[r_wr_ptr] <= w_seq_pc;
    end
  end

  logic w_unused_pop;
  assign w_unused_pop = w_do_pop;

  assign pc_out    = r_pc;
  assign ras_count = r_count;
  assign ras_full  = r_full;
  assign ras_empty = r_empty;
  assign err       = r_err;
  assign trap      = r_trap;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed stimulus for pc_ras_unit with default parameters.
// Ports: drives every DUT input from one initial block, samples outputs 1 time unit after each rising edge.
// The trap scenario is exercised when PC_TRAP_EN is defined; otherwise misaligned targets are taken as given.
module tb_pc_ras_unit;

  logic       clka;
  logic       reset;
  logic       pc_latch_data;
  logic [2:0] pc_ctl;
  logic [5:0] imm;
  logic [5:0] sr1_val;
  logic [5:0] pc_out;
  logic [2:0] ras_count;
  logic       ras_full;
  logic       ras_empty;
  logic       err;
  logic       trap;

  int checks = 0;
  int errors = 0;

  pc_ras_unit dut (
    .clka          (clka),
    .reset         (reset),
    .pc_latch_data (pc_latch_data),
    .pc_ctl        (pc_ctl),
    .imm           (imm),
    .sr1_val       (sr1_val),
    .pc_out        (pc_out),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .err           (err),
    .trap          (trap)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic step(input logic r, input logic l, input logic [2:0] c,
                      input logic [5:0] im, input logic [5:0] s);
    reset         = r;
    pc_latch_data = l;
    pc_ctl        = c;
    imm           = im;
    sr1_val       = s;
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [5:0] e_pc, input logic [2:0] e_cnt,
                           input logic e_full, input logic e_empty, input logic e_err);
    chk({tag, ".pc"},    {26'd0, pc_out},    {26'd0, e_pc});
    chk({tag, ".cnt"},   {29'd0, ras_count}, {29'd0, e_cnt});
    chk({tag, ".full"},  {31'd0, ras_full},  {31'd0, e_full});
    chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, e_empty});
    chk({tag, ".err"},   {31'd0, err},       {31'd0, e_err});
  endtask

  localparam logic [2:0] SEQ = 3'd0, REL = 3'd1, ABS = 3'd2, CALLR = 3'd3, CALLA = 3'd4, RET = 3'd5;

  initial begin
    reset = 1'b1; pc_latch_data = 1'b0; pc_ctl = SEQ; imm = '0; sr1_val = '0;

    // Reset state
    step(1, 0, SEQ, 0, 0);
    chk_state("reset", 0, 0, 0, 1, 0);
    chk("reset.trap", {31'd0, trap}, 32'd0);

    // Sequential stepping and hold
    step(0, 1, SEQ, 0, 0);  chk("seq1", {26'd0, pc_out}, 32'd2);
    step(0, 1, SEQ, 0, 0);  chk("seq2", {26'd0, pc_out}, 32'd4);
    step(0, 1, SEQ, 0, 0);  chk("seq3", {26'd0, pc_out}, 32'd6);
    step(0, 0, CALLA, 0, 20); chk_state("hold", 6, 0, 0, 1, 0);

    // Relative wrap below zero, then sequential wrap back to 0
    step(0, 1, REL, 6'h38, 0); chk("rel_wrap", {26'd0, pc_out}, 32'd62);
    step(0, 1, SEQ, 0, 0);     chk("seq_wrap", {26'd0, pc_out}, 32'd0);
    // 11x behaves as SEQ
    step(0, 1, 3'd6, 6'h3F, 33); chk("ctl110", {26'd0, pc_out}, 32'd2);
    step(0, 1, 3'd7, 6'h3F, 33); chk("ctl111", {26'd0, pc_out}, 32'd4);

    // Nested call/return
    step(0, 1, CALLR, 10, 0); chk_state("callr", 14, 1, 0, 0, 0);
    step(0, 1, CALLA, 0, 40); chk_state("calla", 40, 2, 0, 0, 0);
    step(0, 1, RET, 0, 0);    chk_state("ret1", 16, 1, 0, 0, 0);
    step(0, 1, RET, 0, 0);    chk_state("ret2", 6, 0, 0, 1, 0);

    // Overflow: oldest return address (2) is discarded
    step(1, 1, SEQ, 0, 0);
    step(0, 1, CALLA, 0, 8);  chk_state("ov1", 8, 1, 0, 0, 0);
    step(0, 1, CALLA, 0, 16); chk_state("ov2", 16, 2, 0, 0, 0);
    step(0, 1, CALLA, 0, 24); chk_state("ov3", 24, 3, 0, 0, 0);
    step(0, 1, CALLA, 0, 32); chk_state("ov4", 32, 4, 1, 0, 0);
`ifdef PC_TRAP_EN
    step(0, 1, CALLA, 0, 48); chk_state("ov5_trap", 0, 4, 1, 0, 1);
    chk("ov5.trap", {31'd0, trap}, 32'd1);
    step(0, 1, RET, 0, 0);    chk_state("ovret1", 34 - 8, 3, 0, 0, 1);
`else
    step(0, 1, CALLA, 0, 48); chk_state("ov5", 48, 4, 1, 0, 1);
    step(0, 1, RET, 0, 0);    chk_state("ovret1", 34, 3, 0, 0, 1);
    step(0, 1, RET, 0, 0);    chk_state("ovret2", 26, 2, 0, 0, 1);
    step(0, 1, RET, 0, 0);    chk_state("ovret3", 18, 1, 0, 0, 1);
    step(0, 1, RET, 0, 0);    chk_state("ovret4", 10, 0, 0, 1, 1);
`endif

    // Underflow from a clean state at pc=10
    step(1, 1, SEQ, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, SEQ, 0, 0);
    chk("pre_uf", {26'd0, pc_out}, 32'd10);
`ifdef PC_TRAP_EN
    step(0, 1, RET, 0, 0); chk_state("uf_trap", 0, 0, 0, 1, 1);
    chk("uf.trap", {31'd0, trap}, 32'd1);
`else
    step(0, 1, RET, 0, 0); chk_state("uf", 12, 0, 0, 1, 1);
`endif

    // Reset beats a simultaneous call
    step(0, 1, CALLA, 0, 40);
    step(1, 1, CALLA, 0, 40); chk_state("rst_call", 0, 0, 0, 1, 0);

    // Misaligned absolute target
    step(0, 1, CALLA, 0, 20); chk_state("pre_mis", 20, 1, 0, 0, 0);
`ifdef PC_TRAP_EN
    step(0, 1, ABS, 0, 7); chk_state("mis_trap", 0, 1, 0, 0, 0);
    chk("mis.trap1", {31'd0, trap}, 32'd1);
    step(0, 1, SEQ, 0, 0); chk("mis.trap2", {31'd0, trap}, 32'd0);
    chk("mis.pc2", {26'd0, pc_out}, 32'd2);
`else
    step(0, 1, ABS, 0, 7); chk_state("mis", 7, 1, 0, 0, 0);
    chk("mis.trap", {31'd0, trap}, 32'd0);
    step(0, 1, RET, 0, 0); chk_state("mis_ret", 2, 0, 0, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
